aes_key_expand_seq: RTL and testbench

Iterative AES key-schedule generator that sits directly upstream of the pipelined block-encrypt datapath and drives its `expanded_key` input. It accepts a cipher key through a valid/ready handshake and computes one 32-bit schedule word per cycle into a register file. It then presents all Nr+1 round keys in parallel, holding them stable with a level `ek_valid` until the next key is accepted. It supports the same KEYLEN settings as the encrypt pipeline.

---
 rtl/aes_key_expand_seq.sv | 249 ++++++++++++++++++++++++
 tb/tb_aes_key_expand_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand_seq.sv
// ---------------------------------------------------------------------------
// aes_key_expand_seq
//
// Iterative AES key-schedule generator. A cipher key is taken through a
// valid/ready handshake, then one 32-bit schedule word is produced per clock
// into a word register file. When the last word is written, all Nr+1 round
// keys are presented in parallel and held stable with a level ek_valid until
// the next key is accepted.
//
// Parameters
//   KEYLEN        cipher key width: 128, 192 or 256
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   key_valid     key_in is offered
//   key_ready     block can accept a key (low only while expanding)
//   key_in        cipher key, first key byte in [KEYLEN-1 -: 8]
//   expanded_key  round keys; round r = {w[4r], w[4r+1], w[4r+2], w[4r+3]}
//   ek_valid      high while expanded_key is complete and stable
// ---------------------------------------------------------------------------
module aes_key_expand_seq #(
    parameter int KEYLEN = 128
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             key_valid,
    output logic                             key_ready,
    input  logic [KEYLEN-1:0]                key_in,
    output logic [KEYLEN/32+6:0][127:0]      expanded_key,
    output logic                             ek_valid
);

    localparam int NK = KEYLEN / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    localparam logic [5:0] NK_W   = 6'(NK);
    localparam logic [5:0] I_LAST = 6'(NW - 1);
    localparam logic [2:0] M_LAST = 3'(NK - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Shared byte S-box (forward AES substitution).
    // -----------------------------------------------------------------------
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] s;
        case (x)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b;
            8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b;
            8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d;
            8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf;
            8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26;
            8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1;
            8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3;
            8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2;
            8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a;
            8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3;
            8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed;
            8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39;
            8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb;
            8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f;
            8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f;
            8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21;
            8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec;
            8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d;
            8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc;
            8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14;
            8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a;
            8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62;
            8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d;
            8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea;
            8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e;
            8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f;
            8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66;
            8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9;
            8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11;
            8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9;
            8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d;
            8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f;
            8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] x);
        return {x[23:0], x[31:24]};
    endfunction

    // Multiply by x in GF(2^8) with the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [31:0] w_q [NW];
    logic [31:0] w_d [NW];
    logic [5:0]  i_q, i_d;
    logic [2:0]  m_q, m_d;        // i mod Nk, tracked without a divider
    logic [7:0]  rcon_q, rcon_d;
    logic        ek_valid_q, ek_valid_d;

    logic [31:0] prev_word;
    logic [31:0] back_word;
    logic [31:0] temp_word;
    logic [31:0] new_word;

    // Schedule-word datapath: w[i] = w[i-Nk] ^ f(w[i-1]).
    always_comb begin
        prev_word = w_q[i_q - 6'd1];
        back_word = w_q[i_q - NK_W];
        if (m_q == 3'd0) begin
            temp_word = sub_word(rot_word(prev_word)) ^ {rcon_q, 24'h000000};
        end else if ((NK == 8) && (m_q == 3'd4)) begin
            temp_word = sub_word(prev_word);
        end else begin
            temp_word = prev_word;
        end
        new_word = back_word ^ temp_word;
    end

    // Next-state logic: key acceptance and one word write per EXPAND cycle.
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        m_d        = m_q;
        rcon_d     = rcon_q;
        ek_valid_d = ek_valid_q;
        for (int k = 0; k < NW; k++) begin
            w_d[k] = w_q[k];
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (key_valid) begin
                    for (int j = 0; j < NK; j++) begin
                        w_d[j] = key_in[KEYLEN-1-32*j -: 32];
                    end
                    i_d        = NK_W;
                    m_d        = 3'd0;
                    rcon_d     = 8'h01;
                    ek_valid_d = 1'b0;
                    state_d    = S_EXPAND;
                end else begin
                    state_d = state_q;
                end
            end
            S_EXPAND: begin
                w_d[i_q] = new_word;
                i_d      = i_q + 6'd1;
                m_d      = (m_q == M_LAST) ? 3'd0 : (m_q + 3'd1);
                if (m_q == 3'd0) begin
                    rcon_d = xtime(rcon_q);
                end else begin
                    rcon_d = rcon_q;
                end
                // Last word lands on this edge, so the schedule is complete.
                if (i_q == I_LAST) begin
                    state_d    = S_DONE;
                    ek_valid_d = 1'b1;
                end else begin
                    state_d = S_EXPAND;
                end
            end
            default: begin
                state_d    = S_IDLE;
                ek_valid_d = 1'b0;
            end
        endcase
    end

    // State and word-register update; reset clears the entire schedule.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            i_q        <= 6'd0;
            m_q        <= 3'd0;
            rcon_q     <= 8'h01;
            ek_valid_q <= 1'b0;
            for (int k = 0; k < NW; k++) begin
                w_q[k] <= 32'h00000000;
            end
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            m_q        <= m_d;
            rcon_q     <= rcon_d;
            ek_valid_q <= ek_valid_d;
            for (int k = 0; k < NW; k++) begin
                w_q[k] <= w_d[k];
            end
        end
    end

    // Round-key view: a direct wiring of the word registers.
    always_comb begin
        for (int r = 0; r <= NR; r++) begin
            expanded_key[r] = {w_q[4*r], w_q[4*r+1], w_q[4*r+2], w_q[4*r+3]};
        end
    end

    assign key_ready = (state_q != S_EXPAND);
    assign ek_valid  = ek_valid_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// ---------------------------------------------------------------------------
// tb_aes_key_expand_seq
//
// Directed bench for aes_key_expand_seq. One instance per key length
// (128/192/256) shares clock and reset. Expected values are FIPS-197 and
// well-known AES test vectors; a small independent AES-128 encrypt model
// (S-box derived from GF(2^8) inversion) checks whole schedules end-to-end.
// ---------------------------------------------------------------------------
module tb_aes_key_expand_seq;

    logic clk;
    logic rst;

    logic                kv128, kr128, ev128;
    logic [127:0]        key128;
    logic [10:0][127:0]  ek128;

    logic                kv192, kr192, ev192;
    logic [191:0]        key192;
    logic [12:0][127:0]  ek192;

    logic                kv256, kr256, ev256;
    logic [255:0]        key256;
    logic [14:0][127:0]  ek256;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sbox_tb [256];

    aes_key_expand_seq #(.KEYLEN(128)) u_dut128 (
        .clk(clk), .rst(rst), .key_valid(kv128), .key_ready(kr128),
        .key_in(key128), .expanded_key(ek128), .ek_valid(ev128)
    );

    aes_key_expand_seq #(.KEYLEN(192)) u_dut192 (
        .clk(clk), .rst(rst), .key_valid(kv192), .key_ready(kr192),
        .key_in(key192), .expanded_key(ek192), .ek_valid(ev192)
    );

    aes_key_expand_seq #(.KEYLEN(256)) u_dut256 (
        .clk(clk), .rst(rst), .key_valid(kv256), .key_ready(kr256),
        .key_in(key256), .expanded_key(ek256), .ek_valid(ev256)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference helpers ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [10:0][127:0] ek);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [127:0] ct;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ ek[0][127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_tb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    s[w+4*c] = t[w + 4*((c+w)%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    logic [7:0] a0, a1, a2, a3;
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ ek[r][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
        return ct;
    endfunction

    // ---------------- comparison tasks ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Count edges after the accepting edge until ek_valid is seen (bounded).
    task automatic wait_ev(input int sel, output int n);
        logic ev;
        n = 0;
        while (n < 200) begin
            case (sel)
                0: ev = ev128;
                1: ev = ev192;
                default: ev = ev256;
            endcase
            if (ev === 1'b1) break;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic accept128(input logic [127:0] k);
        key128 = k; kv128 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kv128 = 1'b0;
    endtask

    localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RK1_A  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK10_A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RK10_B = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] RK1_Z  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] RK10_Z = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    int n;
    int ready_hi;

    initial begin
        rst = 1'b1;
        kv128 = 1'b0; kv192 = 1'b0; kv256 = 1'b0;
        key128 = '0; key192 = '0; key256 = '0;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tb[x] = affine(inv);
        end

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        chk_int("rst_ev128", int'(ev128), 0);
        chk_int("rst_ready128", int'(kr128), 1);
        chk("rst_rk0_128", ek128[0], 128'h0);
        chk("rst_rk10_128", ek128[10], 128'h0);
        chk_int("rst_ev256", int'(ev256), 0);
        chk("rst_rk14_256", ek256[14], 128'h0);
        rst = 1'b0;
        @(negedge clk);
        chk_int("idle_ready128", int'(kr128), 1);

        // ---------------- AES-128 FIPS key ----------------
        accept128(KEY_A);
        chk_int("a128_ready_low", int'(kr128), 0);
        wait_ev(0, n);
        chk_int("a128_latency", n, 40);
        chk("a128_rk0", ek128[0], KEY_A);
        chk("a128_rk1", ek128[1], RK1_A);
        chk("a128_rk10", ek128[10], RK10_A);
        chk("a128_encrypt", aes_enc(128'h3243f6a8885a308d313198a2e0370734, ek128),
            128'h3925841d02dc09fbdc118597196a0b32);
        repeat (5) @(negedge clk);
        chk_int("a128_ev_level", int'(ev128), 1);
        chk_int("a128_done_ready", int'(kr128), 1);

        // ---------------- busy rejection with back-to-back key ----------------
        key128 = 128'h0; kv128 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        key128 = KEY_B;
        chk_int("busy_ev_fell", int'(ev128), 0);
        n = 0; ready_hi = 0;
        while (ev128 !== 1'b1 && n < 200) begin
            if (kr128 === 1'b1) ready_hi++;
            @(negedge clk);
            n++;
        end
        chk_int("busy_latency", n, 40);
        chk_int("busy_ready_low_cycles", ready_hi, 0);
        chk("busy_first_rk1", ek128[1], RK1_Z);
        chk("busy_first_rk10", ek128[10], RK10_Z);
        chk("busy_first_encrypt", aes_enc(128'h0, ek128), 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
        @(posedge clk);
        @(negedge clk);
        kv128 = 1'b0;
        chk_int("second_ev_fell", int'(ev128), 0);
        chk_int("second_ready_low", int'(kr128), 0);
        wait_ev(0, n);
        chk_int("second_latency", n, 40);
        chk("second_rk0", ek128[0], KEY_B);
        chk("second_rk10", ek128[10], RK10_B);
        chk("second_encrypt", aes_enc(128'h00112233445566778899aabbccddeeff, ek128),
            128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        // ---------------- AES-192 ----------------
        key192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b; kv192 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kv192 = 1'b0;
        wait_ev(1, n);
        chk_int("a192_latency", n, 46);
        chk("a192_rk0", ek192[0], 128'h8e73b0f7da0e6452c810f32b809079e5);
        chk("a192_w51", {96'h0, ek192[12][31:0]}, 128'h01002202);

        // ---------------- AES-256 ----------------
        key256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        kv256 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kv256 = 1'b0;
        wait_ev(2, n);
        chk_int("a256_latency", n, 52);
        chk("a256_rk1", ek256[1], 128'h1f352c073b6108d72d9810a30914dff4);
        chk("a256_rk14", ek256[14], 128'hfe4890d1e6188d0b046df344706c631e);

        // ---------------- reset mid-expansion ----------------
        accept128(KEY_A);
        repeat (20) @(negedge clk);
        chk_int("mid_ev_low", int'(ev128), 0);
        rst = 1'b1;
        #1;
        chk_int("mid_rst_ev", int'(ev128), 0);
        chk_int("mid_rst_ready", int'(kr128), 1);
        for (int r = 0; r <= 10; r++) chk($sformatf("mid_rst_rk%0d", r), ek128[r], 128'h0);
        @(posedge clk);
        @(negedge clk);
        chk_int("mid_rst_ready_held", int'(kr128), 1);
        rst = 1'b0;
        @(negedge clk);
        accept128(KEY_A);
        wait_ev(0, n);
        chk_int("post_rst_latency", n, 40);
        chk("post_rst_rk10", ek128[10], RK10_A);
        chk("post_rst_encrypt", aes_enc(128'h3243f6a8885a308d313198a2e0370734, ek128),
            128'h3925841d02dc09fbdc118597196a0b32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
